// File: rtl/signed_bcd_decoder.sv
// Signed 16-bit binary to sign + 5-digit BCD, one double-dabble step per cycle.
// Define SIGNED_BCD_SAT_EN to clamp -32768 to 32767 and expose out_sat.
module signed_bcd_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_num,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_neg,
    output logic [19:0] out_bcd
`ifdef SIGNED_BCD_SAT_EN
    ,
    output logic        out_sat
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] mag_q, mag_d;
    logic [19:0] acc_q, acc_d;
    logic [3:0]  step_q, step_d;
    logic        neg_q, neg_d;
    logic        load_out;
    logic [19:0] acc_adj;
    logic [35:0] shifted;
    logic [19:0] acc_step;
    logic [15:0] mag_step;
    logic [19:0] bcd_final;

`ifdef SIGNED_BCD_SAT_EN
    logic sat_q, sat_d;
    logic out_sat_q;
`endif

    function automatic logic [19:0] dabble_adj(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int d = 0; d < 5; d++) begin
            if (b[d*4 +: 4] >= 4'd5)
                r[d*4 +: 4] = b[d*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        acc_adj  = dabble_adj(acc_q);
        shifted  = {acc_adj, mag_q} << 1;
        acc_step = shifted[35:16];
        mag_step = shifted[15:0];
    end

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        acc_d    = acc_q;
        step_d   = step_q;
        neg_d    = neg_q;
        load_out = 1'b0;
`ifdef SIGNED_BCD_SAT_EN
        sat_d    = sat_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CONV;
                    neg_d   = in_num[15];
                    // 0x8000 negates to itself, which reads as 32768 unsigned
                    mag_d   = in_num[15] ? (~in_num + 16'd1) : in_num;
                    acc_d   = 20'h0;
                    step_d  = 4'd0;
`ifdef SIGNED_BCD_SAT_EN
                    sat_d   = (in_num == 16'h8000);
`endif
                end
            end
            CONV: begin
                acc_d  = acc_step;
                mag_d  = mag_step;
                step_d = step_q + 4'd1;
                if (step_q == 4'd15) begin
                    state_d  = DONE;
                    load_out = 1'b1;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SIGNED_BCD_SAT_EN
    assign bcd_final = sat_q ? 20'h32767 : acc_step;
`else
    assign bcd_final = acc_step;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mag_q   <= 16'h0;
            acc_q   <= 20'h0;
            step_q  <= 4'd0;
            neg_q   <= 1'b0;
`ifdef SIGNED_BCD_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            neg_q   <= neg_d;
`ifdef SIGNED_BCD_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

    // Result registers move only when a conversion lands in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            out_neg   <= 1'b0;
            out_bcd   <= 20'h0;
`ifdef SIGNED_BCD_SAT_EN
            out_sat_q <= 1'b0;
`endif
        end else if (load_out) begin
            out_neg   <= neg_q;
            out_bcd   <= bcd_final;
`ifdef SIGNED_BCD_SAT_EN
            out_sat_q <= sat_q;
`endif
        end
    end

`ifdef SIGNED_BCD_SAT_EN
    assign out_sat = out_sat_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

endmodule

// File: tb/tb_signed_bcd_decoder.sv
// Randomized self-checking bench for signed_bcd_decoder.
// Reference converts with integer division, independent of double-dabble.
module tb_signed_bcd_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_num;
    logic        out_valid;
    logic        out_ready;
    logic        out_neg;
    logic [19:0] out_bcd;
`ifdef SIGNED_BCD_SAT_EN
    logic        out_sat;
`endif

    int checks   = 0;
    int failures = 0;

    signed_bcd_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_neg   (out_neg),
        .out_bcd   (out_bcd)
`ifdef SIGNED_BCD_SAT_EN
        ,
        .out_sat   (out_sat)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {neg, bcd} from plain signed arithmetic
    function automatic logic [20:0] model(input logic [15:0] n);
        int v, m;
        logic [19:0] b;
        v = int'($signed(n));
        m = (v < 0) ? -v : v;
`ifdef SIGNED_BCD_SAT_EN
        if (m == 32768) m = 32767;
`endif
        b = '0;
        for (int d = 0; d < 5; d++) begin
            b[d*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {(v < 0), b};
    endfunction

    task automatic check_result(input string tag, input logic [15:0] n);
        logic [20:0] e;
        e = model(n);
        check({tag, "_neg"}, 32'(out_neg), 32'(e[20]));
        check({tag, "_bcd"}, 32'(out_bcd), 32'(e[19:0]));
`ifdef SIGNED_BCD_SAT_EN
        check({tag, "_sat"}, 32'(out_sat), 32'(n == 16'h8000));
`endif
    endtask

    // Called at a negedge while idle; returns at a negedge, idle again
    task automatic run_op(input logic [15:0] n, input int bp);
        check("idle_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_num   = n;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 16; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_num   = 16'($urandom);
            @(negedge clk);
            check("busy_valid", 32'(out_valid), 32'd0);
            check("busy_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'($urandom_range(0, 1));
        in_num   = 16'($urandom);
        @(negedge clk);
        check("lat17_valid", 32'(out_valid), 32'd1);
        check_result("res", n);
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_num   = 16'($urandom);
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ready", 32'(in_ready), 32'd0);
            check_result("bp", n);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_num    = 16'($urandom);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_ready", 32'(in_ready), 32'd1);
        check_result("held", n);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_num    = 16'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_neg", 32'(out_neg), 32'd0);
        check("rst_bcd", 32'(out_bcd), 32'd0);
`ifdef SIGNED_BCD_SAT_EN
        check("rst_sat", 32'(out_sat), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run_op(16'h0005, 0);
        run_op(16'hFFFB, 1);
        run_op(16'h7FFF, 0);
        run_op(16'h8000, 2);
        run_op(16'hD8F1, 5);

        // Abort mid-conversion; last result 0x7FFF must be wiped
        run_op(16'h7FFF, 0);
        in_valid = 1'b1;
        in_num   = 16'h1234;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_bcd", 32'(out_bcd), 32'd0);
        check("abort_neg", 32'(out_neg), 32'd0);
        run_op(16'h0000, 0);

        for (int k = 0; k < 40; k++)
            run_op(16'($urandom), int'($urandom_range(0, 3)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
